// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds funct3 size encodings, the stage FSM states, byte-enable masks,
// and the latched-operation record carried from accept to completion.
package mem_pkg;

    // Funct3 access-size encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Byte-enable masks for a lane-0 access of each size
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    typedef enum logic [1:0] {
        SZ_B,
        SZ_H,
        SZ_W
    } size_t;

    // Operation captured at accept time and replayed into MEM/WB on completion
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] addr;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        mem_to_reg;
        logic        reg_write;
        logic        is_store;
    } op_t;

    // Undefined encodings (011, 110, 111) fall through to word size
    function automatic size_t f3_size(input logic [2:0] f3);
        case (f3)
            F3_B, F3_BU: return SZ_B;
            F3_H, F3_HU: return SZ_H;
            default:     return SZ_W;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Store lane replication / byte enables and load lane select / extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the store and load paths are independent of each other.
// Ports: st_* describe the outgoing store (funct3, addr[1:0], raw data) and
// yield be/wdata; ld_* describe the returning load (funct3, addr[1:0], bus
// word) and yield the extended register value.
module lsu_align
    import mem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_unsigned;

    always_comb begin
        st_be    = BE_WORD;
        st_wdata = st_data;
        case (f3_size(st_funct3))
            SZ_B: begin
                st_be    = BE_BYTE << st_addr_lo;
                st_wdata = {4{st_data[7:0]}};
            end
            SZ_H: begin
                st_be    = BE_HALF << {st_addr_lo[1], 1'b0};
                st_wdata = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte     = ld_rdata[{ld_addr_lo, 3'b000} +: 8];
        ld_half     = ld_rdata[{ld_addr_lo[1], 4'b0000} +: 16];
        ld_unsigned = ld_funct3[2];
        case (f3_size(ld_funct3))
            SZ_B:    ld_data = ld_unsigned ? {24'h0, ld_byte}
                                           : {{24{ld_byte[7]}}, ld_byte};
            SZ_H:    ld_data = ld_unsigned ? {16'h0, ld_half}
                                           : {{16{ld_half[15]}}, ld_half};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage between EX/MEM and MEM/WB with a ready-handshake data bus.
// Latency: 1 cycle for non-memory ops, 2 + wait states for loads/stores, TIMEOUT_CYCLES+2 on abandon.
// Backpressure: mem_stall (combinational) holds upstream from accept until the ready cycle.
// Ports: EX_MEM_* in from execute; dmem_* request/response bus; MEM_WB_* out to
// write-back; mem_misaligned / mem_timeout are registered one-cycle error pulses.
module mem_stage
    import mem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        EX_MEM_enable_out,
    input  logic [31:0] EX_MEM_PC,
    input  logic [31:0] EX_MEM_ALUResult,
    input  logic [31:0] EX_MEM_WriteData,
    input  logic [4:0]  EX_MEM_Rd,
    input  logic [2:0]  EX_MEM_Funct3,
    input  logic        EX_MEM_MemRead,
    input  logic        EX_MEM_MemWrite,
    input  logic        EX_MEM_MemToReg,
    input  logic        EX_MEM_RegWrite,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        mem_stall,
    output logic        mem_misaligned,
    output logic        mem_timeout,
    output logic [31:0] MEM_WB_PC,
    output logic [31:0] MEM_WB_ALUResult,
    output logic [31:0] MEM_WB_ReadData,
    output logic [4:0]  MEM_WB_Rd,
    output logic        MEM_WB_MemToReg,
    output logic        MEM_WB_RegWrite,
    output logic        MEM_WB_enable_out
);

    localparam int             CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LIMIT = CW'(TIMEOUT_CYCLES);

    state_t        state, state_nxt;
    op_t           op_q;
    logic [CW-1:0] cnt_q;
    size_t         ex_size;
    logic          is_mem, misaligned, accept, complete, abandon;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata, ld_data;

    always_comb begin
        is_mem     = EX_MEM_enable_out && (EX_MEM_MemRead || EX_MEM_MemWrite);
        ex_size    = f3_size(EX_MEM_Funct3);
        misaligned = ((ex_size == SZ_H) && EX_MEM_ALUResult[0]) ||
                     ((ex_size == SZ_W) && (EX_MEM_ALUResult[1:0] != 2'b00));
        accept     = (state == IDLE) && is_mem && !misaligned;
    end

    // Gated by reset so every output reads 0 while reset is held
    assign mem_stall = !reset &&
                       (accept || ((state == ACCESS) && !dmem_ready && (cnt_q < CNT_LIMIT)));

    // Store side uses live EX/MEM fields (accept cycle); load side uses the latched op
    lsu_align u_lsu_align (
        .st_funct3  (EX_MEM_Funct3),
        .st_addr_lo (EX_MEM_ALUResult[1:0]),
        .st_data    (EX_MEM_WriteData),
        .st_be      (st_be),
        .st_wdata   (st_wdata),
        .ld_funct3  (op_q.funct3),
        .ld_addr_lo (op_q.addr[1:0]),
        .ld_rdata   (dmem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Ready wins over timeout if both land on the final ACCESS cycle
    always_comb begin
        state_nxt = state;
        complete  = 1'b0;
        abandon   = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = ACCESS;
            end
            ACCESS: begin
                if (dmem_ready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                end else if (cnt_q >= CNT_LIMIT) begin
                    abandon   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q              <= '0;
            cnt_q             <= '0;
            dmem_req          <= 1'b0;
            dmem_we           <= 1'b0;
            dmem_addr         <= 32'h0;
            dmem_wdata        <= 32'h0;
            dmem_be           <= 4'h0;
            mem_misaligned    <= 1'b0;
            mem_timeout       <= 1'b0;
            MEM_WB_PC         <= 32'h0;
            MEM_WB_ALUResult  <= 32'h0;
            MEM_WB_ReadData   <= 32'h0;
            MEM_WB_Rd         <= 5'h0;
            MEM_WB_MemToReg   <= 1'b0;
            MEM_WB_RegWrite   <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
        end else begin
            mem_misaligned    <= 1'b0;
            mem_timeout       <= 1'b0;
            MEM_WB_enable_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (EX_MEM_enable_out && !is_mem) begin
                        MEM_WB_PC         <= EX_MEM_PC;
                        MEM_WB_ALUResult  <= EX_MEM_ALUResult;
                        MEM_WB_ReadData   <= 32'h0;
                        MEM_WB_Rd         <= EX_MEM_Rd;
                        MEM_WB_MemToReg   <= EX_MEM_MemToReg;
                        MEM_WB_RegWrite   <= EX_MEM_RegWrite;
                        MEM_WB_enable_out <= 1'b1;
                    end else if (is_mem && misaligned) begin
                        mem_misaligned <= 1'b1;
                    end else if (accept) begin
                        op_q       <= '{pc: EX_MEM_PC, addr: EX_MEM_ALUResult,
                                        rd: EX_MEM_Rd, funct3: EX_MEM_Funct3,
                                        mem_to_reg: EX_MEM_MemToReg,
                                        reg_write: EX_MEM_RegWrite,
                                        is_store: EX_MEM_MemWrite};
                        cnt_q      <= '0;
                        dmem_req   <= 1'b1;
                        dmem_we    <= EX_MEM_MemWrite;
                        dmem_addr  <= {EX_MEM_ALUResult[31:2], 2'b00};
                        dmem_wdata <= EX_MEM_MemWrite ? st_wdata : 32'h0;
                        dmem_be    <= st_be;
                    end
                end
                ACCESS: begin
                    if (complete) begin
                        dmem_req          <= 1'b0;
                        MEM_WB_PC         <= op_q.pc;
                        MEM_WB_ALUResult  <= op_q.addr;
                        MEM_WB_ReadData   <= op_q.is_store ? 32'h0 : ld_data;
                        MEM_WB_Rd         <= op_q.rd;
                        MEM_WB_MemToReg   <= op_q.mem_to_reg;
                        MEM_WB_RegWrite   <= op_q.reg_write;
                        MEM_WB_enable_out <= 1'b1;
                    end else if (abandon) begin
                        dmem_req    <= 1'b0;
                        mem_timeout <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int TO = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        EX_MEM_enable_out;
    logic [31:0] EX_MEM_PC, EX_MEM_ALUResult, EX_MEM_WriteData;
    logic [4:0]  EX_MEM_Rd;
    logic [2:0]  EX_MEM_Funct3;
    logic        EX_MEM_MemRead, EX_MEM_MemWrite, EX_MEM_MemToReg, EX_MEM_RegWrite;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        mem_stall, mem_misaligned, mem_timeout;
    logic [31:0] MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData;
    logic [4:0]  MEM_WB_Rd;
    logic        MEM_WB_MemToReg, MEM_WB_RegWrite, MEM_WB_enable_out;

    mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .EX_MEM_enable_out(EX_MEM_enable_out), .EX_MEM_PC(EX_MEM_PC),
        .EX_MEM_ALUResult(EX_MEM_ALUResult), .EX_MEM_WriteData(EX_MEM_WriteData),
        .EX_MEM_Rd(EX_MEM_Rd), .EX_MEM_Funct3(EX_MEM_Funct3),
        .EX_MEM_MemRead(EX_MEM_MemRead), .EX_MEM_MemWrite(EX_MEM_MemWrite),
        .EX_MEM_MemToReg(EX_MEM_MemToReg), .EX_MEM_RegWrite(EX_MEM_RegWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .mem_stall(mem_stall),
        .mem_misaligned(mem_misaligned), .mem_timeout(mem_timeout),
        .MEM_WB_PC(MEM_WB_PC), .MEM_WB_ALUResult(MEM_WB_ALUResult),
        .MEM_WB_ReadData(MEM_WB_ReadData), .MEM_WB_Rd(MEM_WB_Rd),
        .MEM_WB_MemToReg(MEM_WB_MemToReg), .MEM_WB_RegWrite(MEM_WB_RegWrite),
        .MEM_WB_enable_out(MEM_WB_enable_out)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] K_WB = 3'b100, K_MIS = 3'b010, K_TO = 3'b001;

    typedef struct packed {
        logic [2:0]  kind;
        logic [31:0] pc, alu, rdata;
        logic [4:0]  rd;
        logic        m2r, rw;
    } ev_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr, wdata, rdata;
        logic [3:0]  be;
        int          wt;
    } bus_t;

    ev_t  exp_q[$];
    bus_t bus_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference load result: shift the addressed lane down, mask to size, extend
    function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] rdata);
        logic [31:0] v;
        v = rdata >> (8 * off);
        case (f3)
            3'b000: begin v &= 32'hFF;   if (v[7])  v |= 32'hFFFF_FF00; end
            3'b100: v &= 32'hFF;
            3'b001: begin v &= 32'hFFFF; if (v[15]) v |= 32'hFFFF_0000; end
            3'b101: v &= 32'hFFFF;
            default: v = rdata;
        endcase
        return v;
    endfunction

    // Present one EX/MEM instruction, record expectations, hold until consumed
    task automatic issue(input logic en, input logic rd_f, input logic wr_f,
                         input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] rd, input logic m2r,
                         input logic rw, input int wt, input logic [31:0] rdata);
        int   sz, exp_stall, n;
        logic [1:0] off;
        bit   memop, mis;
        ev_t  e;
        bus_t b;
        sz    = (f3 == 3'b000 || f3 == 3'b100) ? 1 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 4;
        off   = alu[1:0];
        memop = en && (rd_f || wr_f);
        mis   = memop && ((int'(off) % sz) != 0);
        exp_stall = (memop && !mis) ? 1 + ((wt > TO) ? TO : wt) : 0;
        e = '{kind: K_WB, pc: pc, alu: alu, rdata: 32'h0, rd: rd, m2r: m2r, rw: rw};
        if (en) begin
            if (!memop) exp_q.push_back(e);
            else if (mis) begin e.kind = K_MIS; exp_q.push_back(e); end
            else begin
                b.we    = wr_f;
                b.addr  = alu & 32'hFFFF_FFFC;
                b.be    = 4'(((1 << sz) - 1) << off);
                b.wdata = (sz == 1) ? (wd & 32'hFF) * 32'h0101_0101 :
                          (sz == 2) ? (wd & 32'hFFFF) * 32'h0001_0001 : wd;
                b.wt    = wt;
                b.rdata = rdata;
                bus_q.push_back(b);
                if (wt > TO) e.kind = K_TO;
                else if (!wr_f) e.rdata = exp_load(f3, off, rdata);
                exp_q.push_back(e);
            end
        end
        EX_MEM_enable_out = en;   EX_MEM_PC = pc;        EX_MEM_ALUResult = alu;
        EX_MEM_WriteData  = wd;   EX_MEM_Rd = rd;        EX_MEM_Funct3 = f3;
        EX_MEM_MemRead    = rd_f; EX_MEM_MemWrite = wr_f;
        EX_MEM_MemToReg   = m2r;  EX_MEM_RegWrite = rw;
        n = 0;
        forever begin
            @(negedge clk);
            if (!mem_stall) break;
            n++;
            if (n > 200) break;
        end
        check("stall_cycles", n, exp_stall);
        @(posedge clk); #1;
        EX_MEM_enable_out = 1'b0;
    endtask

    // Bus responder: checks request fields every requested cycle, inserts wait states,
    // and toggles ready randomly while no request is outstanding
    initial begin
        bit   in_acc;
        bus_t cur;
        int   wl;
        in_acc = 0; wl = 0; cur = '0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
        forever begin
            @(posedge clk); #1;
            if (dmem_req) begin
                if (!in_acc) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_req", 128'(dmem_req), 128'(0));
                        dmem_ready = 1'b1;
                    end else begin
                        cur = bus_q.pop_front();
                        in_acc = 1;
                        wl = cur.wt;
                    end
                end
                if (in_acc) begin
                    check("bus_addr", dmem_addr, cur.addr);
                    check("bus_we_be", {dmem_we, dmem_be}, {cur.we, cur.be});
                    if (cur.we) check("bus_wdata", dmem_wdata, cur.wdata);
                    if (wl == 0) begin
                        dmem_ready = 1'b1;
                        dmem_rdata = cur.rdata;
                        in_acc = 0;
                    end else begin
                        wl--;
                        dmem_ready = 1'b0;
                        dmem_rdata = $urandom;
                    end
                end
            end else begin
                in_acc = 0;
                dmem_ready = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the stage reports an outcome
    initial begin
        logic [2:0] k;
        ev_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                k = {MEM_WB_enable_out, mem_misaligned, mem_timeout};
                if (k != 3'b000) begin
                    if (exp_q.size() == 0) check("event_unexpected", 128'(k), 128'(0));
                    else begin
                        e = exp_q.pop_front();
                        check("event_kind", 128'(k), 128'(e.kind));
                        if (e.kind == K_WB)
                            check("mem_wb_fields",
                                  {MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData, MEM_WB_Rd,
                                   MEM_WB_MemToReg, MEM_WB_RegWrite},
                                  {e.pc, e.alu, e.rdata, e.rd, e.m2r, e.rw});
                        if (e.kind == K_TO) check("timeout_req_drop", 128'(dmem_req), 128'(0));
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  f3;
        logic [31:0] alu;
        int          r, m;
        reset = 1'b1;
        EX_MEM_enable_out = 0; EX_MEM_PC = 0; EX_MEM_ALUResult = 0; EX_MEM_WriteData = 0;
        EX_MEM_Rd = 0; EX_MEM_Funct3 = 0; EX_MEM_MemRead = 0; EX_MEM_MemWrite = 0;
        EX_MEM_MemToReg = 0; EX_MEM_RegWrite = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_bus_outs", {dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                                 mem_stall, mem_misaligned, mem_timeout}, 128'(0));
        check("reset_wb_outs", {MEM_WB_PC, MEM_WB_ALUResult, MEM_WB_ReadData, MEM_WB_Rd,
                                MEM_WB_MemToReg, MEM_WB_RegWrite, MEM_WB_enable_out}, 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;

        // Directed cases
        issue(1, 0, 0, 3'b000, 32'h40, 32'h1234, 0, 5'd5, 0, 1, 0, 0);              // ADD
        issue(1, 1, 0, 3'b010, 32'h44, 32'h100, 0, 5'd6, 1, 1, 3, 32'hDEADBEEF);    // LW wait 3
        issue(1, 1, 0, 3'b000, 32'h48, 32'h103, 0, 5'd7, 1, 1, 0, 32'h8000_0000);   // LB
        issue(1, 1, 0, 3'b100, 32'h4C, 32'h103, 0, 5'd8, 1, 1, 1, 32'h8000_0000);   // LBU
        issue(1, 0, 1, 3'b001, 32'h50, 32'h102, 32'h0000ABCD, 5'd0, 0, 0, 0, 0);    // SH
        issue(1, 1, 0, 3'b010, 32'h54, 32'h101, 0, 5'd9, 1, 1, 0, 0);               // LW misaligned
        issue(1, 1, 1, 3'b011, 32'h58, 32'h208, 32'h1122_3344, 5'd3, 0, 0, 2, 0);   // both set, f3 011
        issue(1, 0, 1, 3'b010, 32'h5C, 32'h300, 32'h5555_AAAA, 5'd0, 0, 0, 100000, 0); // SW timeout
        issue(0, 1, 0, 3'b010, 32'h60, 32'h400, 0, 5'd1, 1, 1, 0, 0);               // invalid slot

        // Reset asserted while an access is outstanding
        bus_q.push_back('{we: 0, addr: 32'h200, wdata: 0, rdata: 0, be: 4'hF, wt: 100000});
        EX_MEM_enable_out = 1; EX_MEM_MemRead = 1; EX_MEM_MemWrite = 0;
        EX_MEM_Funct3 = 3'b010; EX_MEM_ALUResult = 32'h200;
        repeat (3) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("reset_mid_req", 128'(dmem_req), 128'(0));
        check("reset_mid_outs", {dmem_we, dmem_addr, dmem_wdata, dmem_be, mem_stall,
                                 MEM_WB_enable_out, MEM_WB_PC, MEM_WB_ALUResult}, 128'(0));
        EX_MEM_enable_out = 0;
        exp_q.delete();
        bus_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            r   = $urandom_range(0, 19);
            f3  = 3'($urandom_range(0, 7));
            alu = $urandom;
            m   = $urandom_range(0, 2);
            if (r < 2)
                issue(0, 1, 0, f3, $urandom, alu, $urandom, 5'($urandom), 1, 1, 0, 0);
            else if (r < 6)
                issue(1, 0, 0, f3, $urandom, alu, $urandom, 5'($urandom),
                      1'($urandom), 1'($urandom), 0, 0);
            else
                issue(1, m != 1, m != 0, f3, $urandom, alu, $urandom, 5'($urandom),
                      1'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom);
        end

        repeat (10) @(posedge clk);
        #1;
        check("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        check("bus_queue_drained", 128'(bus_q.size()), 128'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access pipeline stage placed directly after the execute stage: consumes the EX/MEM register, performs data-memory loads/stores over a ready-handshake bus, and loads the MEM/WB register for write-back. Handles byte/half/word sizing, sign extension, misalignment detection, wait states, and a bus timeout. Drives `mem_stall` into the core's combined stall so upstream stages hold while a bus access is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 64: number of ACCESS cycles without `dmem_ready` before the access is abandoned.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `EX_MEM_enable_out`  in  1  EX/MEM slot holds a valid instruction.
- `EX_MEM_PC`, `EX_MEM_ALUResult`, `EX_MEM_WriteData`  in  32 each  PC, effective address or ALU result, and store data.
- `EX_MEM_Rd`  in  5  destination register.
- `EX_MEM_Funct3`  in  3  access size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `EX_MEM_MemRead`, `EX_MEM_MemWrite`, `EX_MEM_MemToReg`, `EX_MEM_RegWrite`  in  1 each  control.
- `dmem_req`  out  1  bus request.
- `dmem_we`  out  1  1 = store.
- `dmem_addr`  out  32  word-aligned address (`[1:0]` = 0).
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_be`  out  4  byte enables.
- `dmem_ready`  in  1  access completes this cycle.
- `dmem_rdata`  in  32  load data, valid with `dmem_ready`.
- `mem_stall`  out  1  combinational; hold upstream stages.
- `mem_misaligned`  out  1  one-cycle pulse on a misaligned access.
- `mem_timeout`  out  1  one-cycle pulse on an abandoned access.
- `MEM_WB_PC`, `MEM_WB_ALUResult`, `MEM_WB_ReadData`  out  32 each  to write-back.
- `MEM_WB_Rd`  out  5  destination register.
- `MEM_WB_MemToReg`, `MEM_WB_RegWrite`, `MEM_WB_enable_out`  out  1 each  to write-back.

## Operation
- Reset: every output is 0, state is IDLE, and the timeout counter is 0. Reset asserted mid-access drops `dmem_req` immediately and discards the transaction.
- A memory op is `EX_MEM_enable_out & (MemRead | MemWrite)`. If both MemRead and MemWrite are set, the access is a store.
- Misaligned: H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0.
- Undefined funct3 values (011, 110, 111) are treated as W.
- FSM IDLE:
  - Non-memory valid instruction: MEM_WB loads PC, ALUResult, Rd and control; `ReadData` = 0; `enable_out` = 1.
  - Invalid slot: `MEM_WB_enable_out` = 0; other MEM_WB fields hold.
  - Misaligned memory op: no bus access; pulse `mem_misaligned`; `MEM_WB_enable_out` = 0.
  - Aligned memory op: latch all EX/MEM fields internally, register the bus outputs, go to ACCESS.
- FSM ACCESS:
  - `dmem_req` = 1; all bus outputs stay stable until `dmem_ready`.
  - On `dmem_ready`: MEM_WB loads the latched fields plus the extracted load data (0 for stores); `enable_out` = 1; go to IDLE.
  - EX/MEM inputs are ignored while in ACCESS.
  - Counter reaches `TIMEOUT_CYCLES` with no ready: drop req, pulse `mem_timeout`, `MEM_WB_enable_out` = 0, go to IDLE.
- Byte enables:
  - SB: `be` = 0001 << `addr[1:0]`; wdata = byte ×4.
  - SH: `be` = 0011 << (2·`addr[1]`); wdata = half ×2.
  - SW: `be` = 1111.
- Loads: select lane by `addr[1:0]`. B/H are sign-extended; BU/HU are zero-extended.
- `mem_stall` = (IDLE & aligned memory op) | (ACCESS & ~`dmem_ready` & counter < `TIMEOUT_CYCLES`).

## Timing
- Non-memory instruction: 1-cycle latency.
- Memory op with zero wait states: 2 cycles.
  - Cycle 0: accept, stall high.
  - Cycle 1: req with ready.
  - Edge after cycle 1: MEM_WB valid.
- Each wait state adds one cycle.
- `dmem_ready` is ignored in IDLE.
- Stall is low in the ready cycle, so upstream advances on that same edge.
- Timeout counter clears on entry to ACCESS and increments each ACCESS cycle without ready.
- Misaligned ops do not stall.

## Structure
- Package `mem_pkg`:
  - Funct3 size encodings.
  - FSM state enum {IDLE, ACCESS}.
  - Byte-enable constants.
- Sub-module `lsu_align` (combinational): store lane replication and byte enables, load lane select and extension.

## Test plan
- ADD (MemRead=0, ALUResult=0x1234, Rd=5) → next edge: `MEM_WB_ALUResult`=0x1234, `Rd`=5, `enable_out`=1; no req; no stall.
- LW addr 0x100, `rdata`=0xDEADBEEF, ready 3 cycles after req → `mem_stall` high for 4 cycles; `dmem_addr` stable at 0x100; `MEM_WB_ReadData`=0xDEADBEEF.
- LB addr 0x103, `rdata`=0x80000000 → ReadData=0xFFFFFF80. LBU at the same address → ReadData=0x00000080.
- SH addr 0x102, WriteData=0x0000ABCD → `be`=1100, `wdata`=0xABCDABCD, `we`=1.
- LW addr 0x101 → `mem_misaligned` pulse; no req; `MEM_WB_enable_out`=0.
- SW with ready never asserted → `mem_timeout` pulse after 64 ACCESS cycles; req drops. Separately, reset asserted during ACCESS clears req and all outputs in the same cycle.
